arst_n_seq: RTL and testbench

// - Reset generator feeding the async-reset flops downstream: takes raw board arst_n and drives per-domain active-low resets.
// - Assertion is immediate and asynchronous. Deassertion is synchronized to clk, stretched, then released domain-by-domain in index order.
// - Also accepts a synchronous soft-reset request with a handshake. Sits at the top level, one instance per clock.

---
 rtl/arst_n_seq.sv | 157 +++++++++++++++
 tb/tb_arst_n_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arst_n_seq.sv
// arst_n_seq: per-clock reset sequencer.
// Asserts all domain resets asynchronously from arst_n, then synchronizes the
// deassertion, holds, and releases rst_n_o[0..N_DOM-1] in index order.
// A synchronous soft-reset request (sw_rst_req/sw_rst_ack) re-runs the release
// sequence from DONE.
// Optional feature macro ARST_SEQ_REVERSE_EN: soft reset drops domains in
// reverse order GAP_CYC apart (DRAIN state) instead of all at once.
module arst_n_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int N_DOM       = 3,
   parameter int HOLD_CYC    = 8,
   parameter int GAP_CYC     = 4
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             sw_rst_req,
   output logic             sw_rst_ack,
   output logic [N_DOM-1:0] rst_n_o,
   output logic             rst_done,
   output logic             busy
);

   localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int IDX_W   = $clog2(N_DOM + 1);

   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_HOLD  = 3'd1,
      S_REL   = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N_DOM-1:0]   rst_q, rst_d;
   logic               ack_q, ack_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic               sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Synchronizer shifts in a constant 1; arst_n clears every stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   // Sequencing FSM: next state, counters and domain reset bits.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ack_d   = 1'b0;
      case (state_q)
         S_RST: begin
            rst_d = '0;
            if (sync_out) begin
               // The edge on which sync reads 1 already counts as the first
               // hold cycle, so domain 0 releases HOLD_CYC edges after it.
               if (HOLD_CYC == 1) begin
                  state_d  = S_REL;
                  rst_d[0] = 1'b1;
                  idx_d    = IDX_W'(1);
                  cnt_d    = '0;
               end else begin
                  state_d = S_HOLD;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         S_HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
               state_d  = S_REL;
               rst_d[0] = 1'b1;
               idx_d    = IDX_W'(1);
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REL: begin
            if (idx_q == IDX_W'(N_DOM)) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
               for (int i = 0; i < N_DOM; i++)
                  if (idx_q == IDX_W'(i)) rst_d[i] = 1'b1;
               idx_d = idx_q + IDX_W'(1);
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (sw_rst_req) begin
               ack_d = 1'b1;
               cnt_d = '0;
`ifdef ARST_SEQ_REVERSE_EN
               state_d          = S_DRAIN;
               rst_d[N_DOM-1]   = 1'b0;
               idx_d            = IDX_W'(N_DOM - 1);
`else
               state_d = S_HOLD;
               rst_d   = '0;
`endif
            end
         end
`ifdef ARST_SEQ_REVERSE_EN
         S_DRAIN: begin
            // idx_q is the most recently dropped domain.
            if (idx_q == '0) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
               for (int i = 0; i < N_DOM; i++)
                  if (idx_q == IDX_W'(i + 1)) rst_d[i] = 1'b0;
               idx_d = idx_q - IDX_W'(1);
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         default: begin
            state_d = S_RST;
            rst_d   = '0;
         end
      endcase
   end

   // All state clears immediately on arst_n low, without a clock.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_q  <= '0;
         state_q <= S_RST;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ack_q   <= ack_d;
      end
   end

   assign rst_n_o    = rst_q;
   assign sw_rst_ack = ack_q;
   assign rst_done   = (state_q == S_DONE);
   assign busy       = (state_q == S_HOLD) || (state_q == S_REL) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_arst_n_seq.sv
// tb_arst_n_seq: randomized + directed bench for arst_n_seq against an
// edge-count based reference model (honours ARST_SEQ_REVERSE_EN).
module tb_arst_n_seq;

   localparam int SYNC_STAGES = 2;
   localparam int N_DOM       = 3;
   localparam int HOLD_CYC    = 8;
   localparam int GAP_CYC     = 4;
   localparam int W           = N_DOM + 3;

   logic             clk        = 1'b0;
   logic             arst_n     = 1'b0;
   logic             sw_rst_req = 1'b0;
   logic             sw_rst_ack;
   logic [N_DOM-1:0] rst_n_o;
   logic             rst_done;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;

   arst_n_seq #(
      .SYNC_STAGES(SYNC_STAGES), .N_DOM(N_DOM), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk), .arst_n(arst_n), .sw_rst_req(sw_rst_req), .sw_rst_ack(sw_rst_ack),
      .rst_n_o(rst_n_o), .rst_done(rst_done), .busy(busy)
   );

   always #2 clk = ~clk;

   // Reference model: outputs as a function of edges elapsed since the
   // anchoring event (first edge with arst_n high, or soft-reset acceptance).
   typedef enum {M_RST, M_PO, M_SOFT} mmode_t;
   mmode_t           m_mode = M_RST;
   int               m_k = 0, m_anchor = 0, m_d = 0, m_start = 0, m_last = 0;
   logic [N_DOM-1:0] e_rst  = '0;
   logic             e_done = 1'b0, e_busy = 1'b0, e_ack = 1'b0;

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         m_mode = M_RST;
         e_rst  = '0; e_done = 1'b0; e_busy = 1'b0; e_ack = 1'b0;
      end else begin
         m_k++;
         if (m_mode == M_RST) begin
            m_mode = M_PO; m_anchor = m_k;
         end else if (e_done && sw_rst_req) begin
            m_mode = M_SOFT; m_anchor = m_k;
         end
         m_d = m_k - m_anchor;
         if (m_mode == M_PO) begin
            // sync reads 1 one edge after E0; domain i at T+HOLD+i*GAP
            for (int i = 0; i < N_DOM; i++) e_rst[i] = (m_d >= 1 + HOLD_CYC + i*GAP_CYC);
            m_last = 1 + HOLD_CYC + (N_DOM-1)*GAP_CYC;
            e_done = (m_d > m_last);
            e_busy = (m_d >= 2) && !e_done;
            e_ack  = 1'b0;
         end else begin
`ifdef ARST_SEQ_REVERSE_EN
            m_start = (N_DOM-1)*GAP_CYC + 1;
            for (int i = 0; i < N_DOM; i++)
               e_rst[i] = (m_d < (N_DOM-1-i)*GAP_CYC) || (m_d >= m_start + HOLD_CYC + i*GAP_CYC);
`else
            m_start = 0;
            for (int i = 0; i < N_DOM; i++) e_rst[i] = (m_d >= HOLD_CYC + i*GAP_CYC);
`endif
            m_last = m_start + HOLD_CYC + (N_DOM-1)*GAP_CYC;
            e_done = (m_d > m_last);
            e_busy = !e_done;
            e_ack  = (m_d == 0);
         end
      end
   end

   task automatic test_reset();
      logic [W-1:0] got;
      arst_n = 1'b0;
      sw_rst_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         got = {rst_n_o, rst_done, busy, sw_rst_ack};
         n_cmp++;
         if (got !== '0) begin
            n_bad++; $display("FAIL reset c=%0d got=%b exp=0", c, got);
         end
      end
   endtask

   task automatic test_power_on();
      logic [W-1:0] got, exp;
      @(negedge clk); arst_n = 1'b0;
      @(negedge clk); arst_n = 1'b1;
      for (int e = 0; e <= 20; e++) begin
         @(posedge clk); #1;
         got = {rst_n_o, rst_done, busy, sw_rst_ack};
         exp = {e_rst, e_done, e_busy, e_ack};
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL power_on E%0d got=%b exp=%b", e, got, exp);
         end
         if (e == 8 || e == 9 || e == 13 || e == 17) begin
            n_cmp++;
            if (rst_n_o !== ((e == 8) ? 3'b000 : (e == 9) ? 3'b001 : (e == 13) ? 3'b011 : 3'b111)) begin
               n_bad++; $display("FAIL power_on_rst E%0d got=%b", e, rst_n_o);
            end
         end
         if (e == 1 || e == 2 || e == 17 || e == 18) begin
            n_cmp++;
            if ({rst_done, busy} !== ((e == 1) ? 2'b00 : (e == 18) ? 2'b10 : 2'b01)) begin
               n_bad++; $display("FAIL power_on_done_busy E%0d got=%b%b", e, rst_done, busy);
            end
         end
      end
   endtask

   task automatic test_glitch();
      logic [W-1:0] got, exp;
      @(negedge clk); arst_n = 1'b0;
      @(negedge clk); arst_n = 1'b1;
      for (int e = 0; e <= 11; e++) begin
         @(posedge clk); #1;
      end
      arst_n = 1'b0;
      #1;
      got = {rst_n_o, rst_done, busy, sw_rst_ack};
      n_cmp++;
      if (got !== '0) begin
         n_bad++; $display("FAIL glitch_async got=%b exp=0", got);
      end
      #1 arst_n = 1'b1;
      for (int e = 0; e <= 21; e++) begin
         @(posedge clk); #1;
         got = {rst_n_o, rst_done, busy, sw_rst_ack};
         exp = {e_rst, e_done, e_busy, e_ack};
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL glitch_restart E%0d got=%b exp=%b", e, got, exp);
         end
         if (e == 8 || e == 9) begin
            n_cmp++;
            if (rst_n_o[0] !== (e == 9)) begin
               n_bad++; $display("FAIL glitch_dom0 E%0d got=%b", e, rst_n_o[0]);
            end
         end
      end
   endtask

   task automatic test_soft_reset();
      logic [W-1:0] got, exp;
      @(negedge clk); sw_rst_req = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
`ifdef ARST_SEQ_REVERSE_EN
      if ({rst_n_o, sw_rst_ack, rst_done, busy} !== {3'b011, 3'b101}) begin
`else
      if ({rst_n_o, sw_rst_ack, rst_done, busy} !== {3'b000, 3'b101}) begin
`endif
         n_bad++; $display("FAIL soft_accept got rst=%b ack=%b done=%b busy=%b", rst_n_o, sw_rst_ack, rst_done, busy);
      end
      @(negedge clk); sw_rst_req = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk); #1;
         got = {rst_n_o, rst_done, busy, sw_rst_ack};
         exp = {e_rst, e_done, e_busy, e_ack};
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL soft_seq +%0d got=%b exp=%b", e, got, exp);
         end
`ifdef ARST_SEQ_REVERSE_EN
         if (e == 4 || e == 8 || e == 16 || e == 17) begin
            n_cmp++;
            if (rst_n_o !== ((e == 4) ? 3'b001 : (e == 17) ? 3'b001 : 3'b000)) begin
               n_bad++; $display("FAIL soft_rev_rst +%0d got=%b", e, rst_n_o);
            end
         end
`else
         if (e == 1 || e == 7 || e == 8 || e == 16) begin
            n_cmp++;
            if (rst_n_o !== ((e == 8) ? 3'b001 : (e == 16) ? 3'b111 : 3'b000)) begin
               n_bad++; $display("FAIL soft_rst +%0d got=%b", e, rst_n_o);
            end
         end
`endif
         if (e == 1) begin
            n_cmp++;
            if (sw_rst_ack !== 1'b0) begin
               n_bad++; $display("FAIL soft_ack_width got=%b exp=0", sw_rst_ack);
            end
         end
      end
   endtask

   task automatic test_busy_request();
      logic [W-1:0] got, exp;
      @(negedge clk); arst_n = 1'b0;
      @(negedge clk); arst_n = 1'b1;
      for (int e = 0; e <= 21; e++) begin
         sw_rst_req = (e == 12);
         @(posedge clk); #1;
         got = {rst_n_o, rst_done, busy, sw_rst_ack};
         exp = {e_rst, e_done, e_busy, e_ack};
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL busy_req E%0d got=%b exp=%b", e, got, exp);
         end
         n_cmp++;
         if (sw_rst_ack !== 1'b0) begin
            n_bad++; $display("FAIL busy_req_ack E%0d got=%b exp=0", e, sw_rst_ack);
         end
         if (e == 18) begin
            n_cmp++;
            if (rst_done !== 1'b1) begin
               n_bad++; $display("FAIL busy_req_done got=%b exp=1", rst_done);
            end
         end
         @(negedge clk);
      end
      sw_rst_req = 1'b0;
   endtask

   task automatic test_held_request();
      logic [W-1:0] got, exp;
      int acks[$];
`ifdef ARST_SEQ_REVERSE_EN
      int period = HOLD_CYC + 2*(N_DOM-1)*GAP_CYC + 3;
`else
      int period = HOLD_CYC + (N_DOM-1)*GAP_CYC + 2;
`endif
      @(negedge clk); sw_rst_req = 1'b1;
      for (int e = 0; e < 60; e++) begin
         @(posedge clk); #1;
         got = {rst_n_o, rst_done, busy, sw_rst_ack};
         exp = {e_rst, e_done, e_busy, e_ack};
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL held_req e=%0d got=%b exp=%b", e, got, exp);
         end
         if (sw_rst_ack === 1'b1) acks.push_back(e);
      end
      n_cmp++;
      if (acks.size() < 2) begin
         n_bad++; $display("FAIL held_req_count got=%0d exp>=2", acks.size());
      end else begin
         n_cmp++;
         if (acks[1] - acks[0] != period) begin
            n_bad++; $display("FAIL held_req_period got=%0d exp=%0d", acks[1] - acks[0], period);
         end
      end
      @(negedge clk); sw_rst_req = 1'b0;
      for (int e = 0; e < 30; e++) begin
         @(posedge clk); #1;
         got = {rst_n_o, rst_done, busy, sw_rst_ack};
         exp = {e_rst, e_done, e_busy, e_ack};
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL held_settle e=%0d got=%b exp=%b", e, got, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] got, exp;
      int r;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         sw_rst_req = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 199);
         if (!arst_n) begin
            arst_n = 1'b1;
         end else if (r == 0) begin
            arst_n = 1'b0;
         end else if (r == 1) begin
            arst_n = 1'b0;
            #1;
            got = {rst_n_o, rst_done, busy, sw_rst_ack};
            n_cmp++;
            if (got !== '0) begin
               n_bad++; $display("FAIL rand_glitch c=%0d got=%b exp=0", c, got);
            end
            arst_n = 1'b1;
         end
         @(posedge clk); #1;
         got = {rst_n_o, rst_done, busy, sw_rst_ack};
         exp = {e_rst, e_done, e_busy, e_ack};
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL rand c=%0d got=%b exp=%b", c, got, exp);
         end
      end
      @(negedge clk); sw_rst_req = 1'b0; arst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_glitch();
      test_soft_reset();
      test_busy_request();
      test_held_request();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
